// File: rtl/gfx_pkg.sv
// GFX register map, control/status bit positions and the command queue entry layout.
package gfx_pkg;

  localparam int GFX_CONTROL_IDX      = 0;
  localparam int GFX_STATUS_IDX       = 1;
  localparam int GFX_DEST_PIXEL_X_IDX = 14;
  localparam int GFX_DEST_PIXEL_Y_IDX = 15;
  localparam int GFX_DEST_PIXEL_Z_IDX = 16;
  localparam int GFX_COLOR0_IDX       = 33;

  localparam int GFX_CTRL_CHAR            = 0;
  localparam int GFX_CTRL_RECT            = 8;
  localparam int GFX_CTRL_LINE            = 9;
  localparam int GFX_CTRL_TRI             = 10;
  localparam int GFX_CTRL_CURVE           = 11;
  localparam int GFX_CTRL_FORWARD_POINT   = 18;
  localparam int GFX_CTRL_TRANSFORM_POINT = 19;
  localparam int GFX_CTRL_IRQ_EN          = 31;

  localparam int GFX_STAT_BUSY      = 0;
  localparam int GFX_STAT_IRQ       = 1;
  localparam int GFX_STAT_OVF       = 2;
  localparam int GFX_STAT_LEVEL_LSB = 8;
  localparam int GFX_STAT_LEVEL_W   = 5;

  localparam logic [31:0] GFX_START_MASK =
      (32'd1 << GFX_CTRL_CHAR)  | (32'd1 << GFX_CTRL_RECT)  |
      (32'd1 << GFX_CTRL_LINE)  | (32'd1 << GFX_CTRL_TRI)   |
      (32'd1 << GFX_CTRL_CURVE) | (32'd1 << GFX_CTRL_FORWARD_POINT) |
      (32'd1 << GFX_CTRL_TRANSFORM_POINT);

  typedef struct packed {
    logic [31:0] color0;
    logic [31:0] dest_z;
    logic [31:0] dest_y;
    logic [31:0] dest_x;
    logic [31:0] ctrl;
  } gfx_cmd_t;

  // Byte-lane merge of a 32-bit register; only lanes 0..3 exist in a register.
  function automatic logic [31:0] gfx_merge(input logic [31:0] old,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return (old & ~m) | (wdat & m);
  endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Command queue: flop storage with level counter; head comes from storage, never from data_i.
module gfx_cmd_fifo #(
  parameter int W     = 160,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o,
  output logic [W-1:0]     head_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [LVL_W-1:0]        level;
  logic                    push, pop;

  assign valid_o = (level != '0);
  assign full_o  = (level == LVL_W'(DEPTH));
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & valid_o;
  assign level_o = level;
  assign head_o  = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      level <= level + LVL_W'(1);
      else if (pop & ~push) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/gfx_cmd_regfile.sv
// GFX register block: bus slave over the register map, live register image, and a
// command queue fed by start writes to CONTROL.
module gfx_cmd_regfile
  import gfx_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int NREG   = 51,
  parameter int QDEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cs_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic [NREG*32-1:0]  regs_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [159:0]        cmd_o,
  input  logic                engine_busy_i,
  output logic                irq_o
);
  localparam int OFFS  = $clog2(DATA_W / 8);
  localparam int IDX_W = ADDR_W - OFFS;
  localparam int LVL_W = $clog2(QDEPTH + 1);

  logic [NREG-1:0][31:0] regs_q;
  logic                  irq_q, ovf_q, busy_q;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           wdata, ctrl_new, status, rd_data;
  logic                  acc, wr, ctrl_wr, stat_wr, start, stall, push, done;
  logic                  fifo_full, pop, busy, irq_set;
  logic [LVL_W-1:0]      level;
  gfx_cmd_t              push_cmd;
  logic                  unused_ok;

  assign idx     = adr_i[ADDR_W-1:OFFS];
  assign wdata   = dat_i[31:0];
  // ack_o high blocks resampling, so a held cs_i cannot double-ack.
  assign acc     = cs_i & ~ack_o;
  assign wr      = acc & we_i;
  assign ctrl_wr = wr & (int'(idx) == GFX_CONTROL_IDX);
  assign stat_wr = wr & (int'(idx) == GFX_STATUS_IDX);

  assign ctrl_new = gfx_merge(regs_q[GFX_CONTROL_IDX], wdata, sel_i[3:0]);
  assign start    = ctrl_wr & (|(ctrl_new & GFX_START_MASK));
  // A start into a full queue is neither acked nor applied until a slot frees.
  assign stall    = start & fifo_full;
  assign push     = start & ~fifo_full;
  assign done     = acc & ~stall;

  assign push_cmd = '{color0: regs_q[GFX_COLOR0_IDX],
                      dest_z: regs_q[GFX_DEST_PIXEL_Z_IDX],
                      dest_y: regs_q[GFX_DEST_PIXEL_Y_IDX],
                      dest_x: regs_q[GFX_DEST_PIXEL_X_IDX],
                      ctrl:   ctrl_new};

  assign pop     = cmd_valid_o & cmd_ready_i;
  assign busy    = engine_busy_i | cmd_valid_o;
  assign irq_set = busy_q & ~busy & regs_q[GFX_CONTROL_IDX][GFX_CTRL_IRQ_EN];
  assign irq_o   = irq_q;

  gfx_cmd_fifo #(
    .W     ($bits(gfx_cmd_t)),
    .DEPTH (QDEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .valid_o (cmd_valid_o),
    .full_o  (fifo_full),
    .level_o (level),
    .head_o  (cmd_o)
  );

  always_comb begin
    status = '0;
    status[GFX_STAT_BUSY] = busy;
    status[GFX_STAT_IRQ]  = irq_q;
    status[GFX_STAT_OVF]  = ovf_q;
    status[GFX_STAT_LEVEL_LSB +: GFX_STAT_LEVEL_W] = GFX_STAT_LEVEL_W'(level);
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NREG; k++)
      if (int'(idx) == k) rd_data = (k == GFX_STATUS_IDX) ? status : regs_q[k];
  end

  for (genvar k = 0; k < NREG; k++) begin : g_img
    if (k == GFX_STATUS_IDX) begin : g_stat
      assign regs_o[32*k +: 32] = status;
    end else begin : g_reg
      assign regs_o[32*k +: 32] = regs_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
      ack_o  <= 1'b0;
      dat_o  <= '0;
      irq_q  <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_o  <= done;
      busy_q <= busy;
      if (done & ~we_i) dat_o <= DATA_W'(rd_data);
      if (done & we_i) begin
        for (int k = 0; k < NREG; k++)
          if (int'(idx) == k && k != GFX_STATUS_IDX)
            regs_q[k] <= (k == GFX_CONTROL_IDX) ? (ctrl_new & ~GFX_START_MASK)
                                                : gfx_merge(regs_q[k], wdata, sel_i[3:0]);
      end
      // Set beats a same-cycle clear for both sticky flags.
      if (irq_set)                                        irq_q <= 1'b1;
      else if (stat_wr & sel_i[0] & wdata[GFX_STAT_IRQ])  irq_q <= 1'b0;
      if (stall)                                          ovf_q <= 1'b1;
      else if (stat_wr & sel_i[0] & wdata[GFX_STAT_OVF])  ovf_q <= 1'b0;
    end
  end

  assign unused_ok = ^{dat_i, sel_i, adr_i, regs_q[GFX_STATUS_IDX]};

endmodule

// File: tb/tb_gfx_cmd_regfile.sv
// Directed + randomized bench for gfx_cmd_regfile against a queue/array reference model.
module tb_gfx_cmd_regfile;
  localparam int NREG = 51;
  localparam int QD   = 4;
  localparam logic [31:0] START_BITS = 32'h000C_0F01;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              cs = 1'b0, we = 1'b0, cready = 1'b0, ebusy = 1'b0;
  logic [7:0]        sel = '0;
  logic [8:0]        adr = '0;
  logic [63:0]       wd = '0, rd;
  logic              ack, cvalid, irq;
  logic [NREG*32-1:0] regs;
  logic [159:0]      cmd;

  logic              cs_b = 1'b0, we_b = 1'b0, cready_b = 1'b0, ebusy_b = 1'b0;
  logic [3:0]        sel_b = '0;
  logic [8:0]        adr_b = '0;
  logic [31:0]       wd_b = '0, rd_b;
  logic              ack_b, cvalid_b, irq_b;
  logic [NREG*32-1:0] regs_b;
  logic [159:0]      cmd_b;

  gfx_cmd_regfile #(.DATA_W(64), .ADDR_W(9), .NREG(NREG), .QDEPTH(QD)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .sel_i(sel), .adr_i(adr),
    .dat_i(wd), .dat_o(rd), .ack_o(ack), .regs_o(regs), .cmd_valid_o(cvalid),
    .cmd_ready_i(cready), .cmd_o(cmd), .engine_busy_i(ebusy), .irq_o(irq));

  gfx_cmd_regfile #(.DATA_W(32), .ADDR_W(9), .NREG(NREG), .QDEPTH(QD)) dut_b (
    .clk_i(clk), .rst_i(rst), .cs_i(cs_b), .we_i(we_b), .sel_i(sel_b), .adr_i(adr_b),
    .dat_i(wd_b), .dat_o(rd_b), .ack_o(ack_b), .regs_o(regs_b), .cmd_valid_o(cvalid_b),
    .cmd_ready_i(cready_b), .cmd_o(cmd_b), .engine_busy_i(ebusy_b), .irq_o(irq_b));

  always #5 clk = ~clk;

  int ncomp = 0, nfail = 0;
  int start_pos[7] = '{0, 8, 9, 10, 11, 18, 19};

  logic [31:0]  m_regs[NREG];
  logic [159:0] m_q[$];
  bit           m_irq = 1'b0, m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (m_q.size() != 0) || ebusy;
    s[1]    = m_irq;
    s[2]    = m_ovf;
    s[12:8] = 5'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input int i);
    if (i >= NREG) return 32'h0;
    if (i == 1) return m_status();
    return m_regs[i];
  endfunction

  task automatic m_write(input int i, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] mk, nw;
    mk = '0;
    for (int b = 0; b < 4; b++) if (s[b]) mk[8*b +: 8] = 8'hFF;
    if (i >= NREG) return;
    if (i == 1) begin
      if (s[0] && d[1]) m_irq = 1'b0;
      if (s[0] && d[2]) m_ovf = 1'b0;
      return;
    end
    nw = (m_regs[i] & ~mk) | (d & mk);
    if (i == 0 && (nw & START_BITS) != 0) begin
      if (m_q.size() < QD) m_q.push_back({m_regs[33], m_regs[16], m_regs[15], m_regs[14], nw});
      nw = nw & ~START_BITS;
    end
    m_regs[i] = nw;
  endtask

  task automatic xfer(input bit w, input int i, input logic [31:0] d, input logic [7:0] s,
                      output logic [63:0] rdat, output int lat);
    cs = 1'b1; we = w; adr = 9'(i * 8); wd = {$urandom(), d}; sel = s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 20);
    rdat = rd;
    cs = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 1'b0);
  endtask

  task automatic wr(input int i, input logic [31:0] d, input logic [7:0] s);
    logic [63:0] r;
    int lat;
    xfer(1'b1, i, d, s, r, lat);
    chk("wr_lat", lat, 1);
    m_write(i, d, s);
  endtask

  task automatic rdchk(input int i);
    logic [63:0] r;
    int lat;
    xfer(1'b0, i, 32'h0, 8'hFF, r, lat);
    chk("rd_lat", lat, 1);
    chk($sformatf("rd_idx%0d", i), r, {32'h0, m_read(i)});
  endtask

  task automatic pop1();
    chk("cmd_valid", cvalid, m_q.size() != 0);
    if (m_q.size() != 0) chk("cmd_head", cmd, m_q[0]);
    cready = 1'b1;
    @(posedge clk); #1;
    cready = 1'b0;
    if (m_q.size() != 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0 && !ebusy && m_regs[0][31]) m_irq = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic pushpop(input logic [31:0] w);
    chk("pp_head", cmd, m_q[0]);
    cs = 1'b1; we = 1'b1; adr = '0; wd = {32'h0, w}; sel = 8'h0F; cready = 1'b1;
    @(posedge clk); #1;
    cready = 1'b0; cs = 1'b0; we = 1'b0;
    chk("pp_ack", ack, 1'b1);
    void'(m_q.pop_front());
    m_write(0, w, 8'h0F);
    @(posedge clk); #1;
    chk("pp_level", regs[32+8 +: 5], 5'd2);
  endtask

  task automatic xfer_b(input bit w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rdat, output int lat);
    cs_b = 1'b1; we_b = w; adr_b = a; wd_b = d; sel_b = s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack_b && lat < 20);
    rdat = rd_b;
    cs_b = 1'b0; we_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    logic [31:0] rb, d;
    int lat, op, i;
    bit seen;
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;

    // Reset, including a transfer presented during reset which must be dropped.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", rd, 64'h0);
    chk("rst_cvalid", cvalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_regs_zero", regs == '0, 1'b1);
    cs = 1'b1; we = 1'b1; adr = 9'h070; wd = 64'h1234; sel = 8'hFF;
    @(posedge clk); #1;
    chk("rst_drop_ack", ack, 1'b0);
    cs = 1'b0; we = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_reg", regs[14*32 +: 32], 32'h0);
    chk("rst_no_late_ack", ack, 1'b0);

    for (int k = 0; k < 64; k++) rdchk(k);

    // Start write captures dest/color; CONTROL keeps only non-start bits.
    wr(14, 32'h0001_0040, 8'h0F);
    wr(15, 32'h0000_0020, 8'h0F);
    wr(33, 32'h00FF_00FF, 8'h0F);
    wr(0, 32'h0000_0100, 8'h0F);
    chk("first_cmd_valid", cvalid, 1'b1);
    chk("first_cmd", cmd, {32'h00FF00FF, 32'h0, 32'h20, 32'h00010040, 32'h100});
    rdchk(0);
    pop1();

    // Fill the queue, then a fifth start stalls until a pop frees a slot.
    for (int k = 0; k < 4; k++) wr(0, 32'h0000_0200, 8'h0F);
    chk("full_status", regs[32 +: 32], 32'h0000_0401);
    cs = 1'b1; we = 1'b1; adr = '0; wd = {32'h0, 32'h200}; sel = 8'h0F;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (ack) seen = 1'b1; end
    chk("stall_no_ack", seen, 1'b0);
    chk("stall_head", cmd, m_q[0]);
    cready = 1'b1;
    @(posedge clk); #1;
    cready = 1'b0;
    void'(m_q.pop_front());
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 20);
    chk("stall_release_lat", lat, 1);
    cs = 1'b0; we = 1'b0;
    m_write(0, 32'h200, 8'h0F);
    m_ovf = 1'b1;
    @(posedge clk); #1;
    chk("ovf_level", regs[32 +: 32], 32'h0000_0405);
    rdchk(1);
    wr(1, 32'h4, 8'h01);
    rdchk(1);

    // Simultaneous push/pop at level 2, wrapping the pointers twice.
    pop1();
    pop1();
    for (int k = 0; k < 8; k++) pushpop(32'h0000_0400 | (32'(k) << 20));
    rdchk(1);
    while (m_q.size() != 0) pop1();

    // Interrupt on busy falling edge with IRQ_EN set.
    wr(0, 32'h8000_0100, 8'h0F);
    ebusy = 1'b1;
    pop1();
    @(posedge clk); #1;
    ebusy = 1'b0;
    chk("irq_before_fall", irq, 1'b0);
    @(posedge clk); #1;
    m_irq = 1'b1;
    chk("irq_after_fall", irq, 1'b1);
    rdchk(1);
    wr(1, 32'h2, 8'h01);
    chk("irq_cleared", irq, 1'b0);

    // Randomized register/queue traffic.
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          i = $urandom_range(1, 63);
          wr(i, $urandom(), 8'($urandom()));
        end
        1: rdchk($urandom_range(0, 63));
        2: if (m_q.size() < QD) begin
          d = $urandom() | (32'h1 << start_pos[$urandom_range(0, 6)]);
          wr(0, d, 8'h0F | 8'($urandom() & 32'hF0));
        end
        3: pop1();
        default: wr(0, $urandom() & ~START_BITS, 8'($urandom()));
      endcase
      chk("rand_irq", irq, m_irq);
      chk("rand_cvalid", cvalid, m_q.size() != 0);
    end
    for (int k = 0; k < NREG; k++)
      chk($sformatf("image_%0d", k), regs[32*k +: 32], (k == 1) ? m_status() : m_regs[k]);

    // 32-bit bus build: upper lanes of a register are unmasked per sel, off-map reads 0.
    xfer_b(1'b1, 9'h038, 32'hAAAA_BBBB, 4'b0011, rb, lat);
    chk("b_wr_lat", lat, 1);
    chk("b_destx", regs_b[14*32 +: 32], 32'h0000_BBBB);
    xfer_b(1'b0, 9'h038, 32'h0, 4'hF, rb, lat);
    chk("b_rd_destx", rb, 32'h0000_BBBB);
    xfer_b(1'b0, 9'h1FC, 32'h0, 4'hF, rb, lat);
    chk("b_rd_offmap_lat", lat, 1);
    chk("b_rd_offmap", rb, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/gfx_cmd_regfile.md
Name: gfx_cmd_regfile

Overview:
- Parametrised next-generation register block for the GFX accelerator: a bus slave that decodes the GFX register map at a configurable data width.
- Holds all parameter registers and exports them live.
- Turns writes to the control register that start an operation into entries in a command queue. Each entry also captures the destination point and color0 at push time.
- Sits between the system bus and the raster/transform pipeline; the pipeline consumes the queue through a valid/ready handshake.

Parameters:
- DATA_W, 64, bus data width; only 32 and 64 are legal. Register stride = DATA_W/8 bytes.
- ADDR_W, 9, bus byte-address width.
- NREG, 51, number of 32-bit registers. Index = adr_i >> log2(DATA_W/8).
- QDEPTH, 4, command queue depth; a power of two, 2..16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- cs_i  in  1  cycle & strobe.
- we_i  in  1  write enable.
- sel_i  in  DATA_W/8  byte enables.
- adr_i  in  ADDR_W  byte address.
- dat_i  in  DATA_W  write data.
- dat_o  out  DATA_W  read data.
- ack_o  out  1  transfer acknowledge.
- regs_o  out  NREG*32  live register image; register k is at bits [32k+31:32k].
- cmd_valid_o  out  1  queue head valid.
- cmd_ready_i  in  1  engine accepts head.
- cmd_o  out  160  head entry: {color0, dest_z, dest_y, dest_x, ctrl}, ctrl in [31:0].
- engine_busy_i  in  1  engine executing a command.
- irq_o  out  1  operation-complete interrupt.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: all registers 0, queue empty, dat_o=0, ack_o=0, cmd_valid_o=0, irq_o=0, overflow flag=0. Reset mid-transfer drops the transfer and no ack is issued.
- Bus handshake:
  - ack_o is registered and asserts one cycle after cs_i is sampled high. It is held for one cycle only.
  - A new access may be sampled the cycle after ack; cs_i held high across ack does not double-ack.
- Reads: dat_o = zero-extended 32-bit register, valid with ack_o. Index >= NREG or misaligned high lanes read 0.
- Writes: only byte lanes 0..3 of sel_i apply; upper lanes are ignored at DATA_W=64. Index >= NREG is acked and has no effect.
- Start bits: a control write is a "start" if the written word has any of CHAR(0), RECT(8), LINE(9), TRI(10), CURVE(11), FORWARD_POINT(18), TRANSFORM_POINT(19) set.
- Start write, queue not full:
  - The entry is pushed the same cycle as the register update.
  - dest_x/y/z and color0 are captured from their current values; a same-cycle write cannot target them.
  - The control register stores the word with the start bits cleared, so the mode bits persist.
- Start write, queue full: ack is withheld (bus stall) until a pop frees a slot. The push and ack then occur in the cycle after the slot frees, and the overflow flag is set sticky.
- Queue:
  - FIFO of QDEPTH entries with a level counter 0..QDEPTH.
  - cmd_valid_o = level != 0; cmd_o = head entry (registered, no fall-through).
  - Pop when cmd_valid_o & cmd_ready_i.
  - Simultaneous push and pop leaves the level unchanged; pointers wrap modulo QDEPTH.
- STATUS register (index 1) is read-only computed:
  - bit0 busy = engine_busy_i | cmd_valid_o.
  - bit1 irq pending.
  - bit2 overflow.
  - bits[12:8] level.
  - A write with bit1=1 clears irq; a write with bit2=1 clears overflow. Clear and set in the same cycle: set wins.
- irq: set on the falling edge of busy (registered previous busy = 1, current = 0), only if CONTROL bit 31 (irq enable) is 1. irq_o = irq pending.

Decomposition:
- Shared package gfx_pkg:
  - register indices (byte offset / 8, e.g. GFX_CONTROL_IDX=0, GFX_STATUS_IDX=1, GFX_DEST_PIXEL_X_IDX=14, Y=15, Z=16, GFX_COLOR0_IDX=33);
  - control bit positions plus GFX_CTRL_IRQ_EN=31;
  - status bit positions;
  - a GFX_START_MASK constant;
  - a packed struct gfx_cmd_t for the 160-bit entry.
- One sub-module: gfx_cmd_fifo (parametrised width/depth, level output, registered head).

Test Plan:
- Reset then read every index at DATA_W=64 -> all 0, STATUS=0. Each ack is exactly one cycle after cs_i.
- Write 0x0001_0040 to DEST_X (adr 0x070), 0x20 to DEST_Y, 0x00FF00FF to COLOR0, then 0x0000_0100 to CONTROL -> cmd_valid_o=1; cmd_o ctrl=0x100, dest_x=0x00010040, dest_y=0x20, color0=0x00FF00FF. CONTROL reads back 0.
- QDEPTH=4, cmd_ready_i=0, five LINE starts -> level=4. Fifth ack is withheld; raise cmd_ready_i one cycle -> fifth ack follows and overflow=1. Writing STATUS=0x4 clears overflow.
- Push and pop in the same cycle at level 2 -> level stays 2. Eight push/pop cycles -> entries are emitted in order across the wrap.
- CONTROL bit31 set, one RECT, engine_busy_i pulses 1 for 3 cycles then 0 -> irq_o=1 the cycle after busy drops. Write STATUS=0x2 -> irq_o=0.
- DATA_W=32 build: write adr 0x038 (index 14) with sel_i=4'b0011 of 0xAAAABBBB -> DEST_X=0x0000BBBB; adr 0x1FC reads 0 with ack.
